// File: rtl/rv32_csr_irq.sv
// Machine-mode CSR file for the RV32 core: cycle/instret counters, interrupt
// pending/enable with fixed-priority arbitration, and trap/MRET state.
module rv32_csr_irq #(
    parameter int unsigned NUM_LOCAL_IRQ = 4,
    parameter int unsigned COUNTER_WIDTH = 64,
    parameter logic [31:0] ADDR_MASK     = 32'h00FF_FFFF,
    parameter logic [31:0] HART_ID       = 32'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [11:0]              csr_addr,
    input  logic [31:0]              csr_wdata,
    input  logic                     csr_we,
    input  logic [2:0]               csr_op,
    output logic [31:0]              csr_rdata,
    output logic                     csr_illegal,
    input  logic                     instr_retire,
    input  logic                     trap_trigger,
    input  logic [31:0]              trap_cause,
    input  logic [31:0]              trap_pc,
    input  logic [31:0]              trap_value,
    input  logic                     mret_trigger,
    input  logic                     timer_interrupt,
    input  logic                     external_interrupt,
    input  logic                     software_interrupt,
    input  logic [NUM_LOCAL_IRQ-1:0] local_irq,
    output logic                     irq_req,
    output logic [31:0]              irq_cause,
    output logic [31:0]              trap_vector,
    output logic [31:0]              mepc_out,
    output logic [31:0]              mstatus_out,
    output logic [31:0]              mie_out,
    output logic [31:0]              mip_out
);

    localparam logic [11:0] ADDR_MSTATUS       = 12'h300;
    localparam logic [11:0] ADDR_MISA          = 12'h301;
    localparam logic [11:0] ADDR_MEDELEG       = 12'h302;
    localparam logic [11:0] ADDR_MIDELEG       = 12'h303;
    localparam logic [11:0] ADDR_MIE           = 12'h304;
    localparam logic [11:0] ADDR_MTVEC         = 12'h305;
    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] ADDR_MSCRATCH      = 12'h340;
    localparam logic [11:0] ADDR_MEPC          = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE        = 12'h342;
    localparam logic [11:0] ADDR_MTVAL         = 12'h343;
    localparam logic [11:0] ADDR_MIP           = 12'h344;
    localparam logic [11:0] ADDR_SATP          = 12'h180;
    localparam logic [11:0] ADDR_PMPCFG0       = 12'h3A0;
    localparam logic [11:0] ADDR_PMPADDR0      = 12'h3B0;
    localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
    localparam logic [11:0] ADDR_TIME          = 12'hC01;
    localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
    localparam logic [11:0] ADDR_TIMEH         = 12'hC81;
    localparam logic [11:0] ADDR_INSTRETH      = 12'hC82;
    localparam logic [11:0] ADDR_MVENDORID     = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID       = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID        = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID       = 12'hF14;

    localparam logic [31:0] MISA_VALUE   = 32'h4000_0104;
    localparam logic [31:0] MSTATUS_MASK = 32'h0000_1FFF;
    localparam logic [31:0] MCAUSE_MASK  = 32'h8000_001F;
    localparam logic [31:0] MCINH_MASK   = 32'h0000_0005;
    localparam logic [31:0] LOCAL_MASK   = ((32'd1 << NUM_LOCAL_IRQ) - 32'd1) << 16;
    localparam logic [31:0] MIE_MASK     = 32'h0000_0888 | LOCAL_MASK;
    localparam logic [31:0] MSTATUS_RST  = 32'h0000_1800;
    localparam logic [63:0] CNT_MASK     = (COUNTER_WIDTH >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                                 : ((64'd1 << COUNTER_WIDTH) - 64'd1);

    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mcountinhibit_q, mcountinhibit_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;
    logic        msip_q, msip_d;
    logic        mtip_q, mtip_d;
    logic        meip_q, meip_d;
    logic [NUM_LOCAL_IRQ-1:0] lpend_q, lpend_d;
    logic [NUM_LOCAL_IRQ-1:0] lirq_q, lirq_d;

    logic [31:0] mip_val;
    logic [31:0] irq_pend;
    logic [31:0] src;
    logic [31:0] wval;
    logic        wr_en;
    logic        addr_ok;
    logic        addr_ro;
    logic [NUM_LOCAL_IRQ-1:0] local_clear;
    logic [31:0] vec_base;

    // Live view of the pending register.
    always_comb begin
        mip_val                    = '0;
        mip_val[3]                 = msip_q;
        mip_val[7]                 = mtip_q;
        mip_val[11]                = meip_q;
        mip_val[16+:NUM_LOCAL_IRQ] = lpend_q;
    end

    // Combinational read mux and address decode.
    always_comb begin
        csr_rdata = '0;
        addr_ok   = 1'b1;
        addr_ro   = 1'b0;
        case (csr_addr)
            ADDR_MSTATUS:       csr_rdata = mstatus_q;
            ADDR_MISA:          csr_rdata = MISA_VALUE;
            ADDR_MIE:           csr_rdata = mie_q;
            ADDR_MTVEC:         csr_rdata = mtvec_q;
            ADDR_MCOUNTINHIBIT: csr_rdata = mcountinhibit_q;
            ADDR_MSCRATCH:      csr_rdata = mscratch_q;
            ADDR_MEPC:          csr_rdata = mepc_q;
            ADDR_MCAUSE:        csr_rdata = mcause_q;
            ADDR_MTVAL:         csr_rdata = mtval_q;
            ADDR_MIP:           csr_rdata = mip_val;
            ADDR_MCYCLE:        csr_rdata = mcycle_q[31:0];
            ADDR_MCYCLEH:       csr_rdata = mcycle_q[63:32];
            ADDR_MINSTRET:      csr_rdata = minstret_q[31:0];
            ADDR_MINSTRETH:     csr_rdata = minstret_q[63:32];
            ADDR_CYCLE, ADDR_TIME: begin
                csr_rdata = mcycle_q[31:0];
                addr_ro   = 1'b1;
            end
            ADDR_CYCLEH, ADDR_TIMEH: begin
                csr_rdata = mcycle_q[63:32];
                addr_ro   = 1'b1;
            end
            ADDR_INSTRET: begin
                csr_rdata = minstret_q[31:0];
                addr_ro   = 1'b1;
            end
            ADDR_INSTRETH: begin
                csr_rdata = minstret_q[63:32];
                addr_ro   = 1'b1;
            end
            ADDR_MEDELEG, ADDR_MIDELEG, ADDR_SATP, ADDR_PMPCFG0, ADDR_PMPADDR0: csr_rdata = '0;
            ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID: addr_ro = 1'b1;
            ADDR_MHARTID: begin
                csr_rdata = HART_ID;
                addr_ro   = 1'b1;
            end
            default: addr_ok = 1'b0;
        endcase
        csr_illegal = !addr_ok || (csr_we && addr_ro);
    end

    // Read-modify-write operand for the three access flavours.
    always_comb begin
        src = csr_op[2] ? {27'd0, csr_wdata[4:0]} : csr_wdata;
        case (csr_op[1:0])
            2'b01:   wval = src;
            2'b10:   wval = csr_rdata | src;
            2'b11:   wval = csr_rdata & ~src;
            default: wval = csr_rdata;
        endcase
        wr_en = csr_we && (csr_op[1:0] != 2'b00) && !csr_illegal;
    end

    // Next-state: counters, CSR writes, then trap/MRET overrides.
    always_comb begin
        mstatus_d       = mstatus_q;
        mie_d           = mie_q;
        mtvec_d         = mtvec_q;
        mcountinhibit_d = mcountinhibit_q;
        mscratch_d      = mscratch_q;
        mepc_d          = mepc_q;
        mcause_d        = mcause_q;
        mtval_d         = mtval_q;
        mcycle_d        = mcycle_q;
        minstret_d      = minstret_q;
        msip_d          = software_interrupt;
        mtip_d          = timer_interrupt;
        meip_d          = external_interrupt;
        lirq_d          = local_irq;
        local_clear     = '0;

        if (!mcountinhibit_q[0]) mcycle_d = (mcycle_q + 64'd1) & CNT_MASK;
        if (!mcountinhibit_q[2] && instr_retire) minstret_d = (minstret_q + 64'd1) & CNT_MASK;

        if (wr_en) begin
            case (csr_addr)
                ADDR_MSTATUS:       mstatus_d = wval & MSTATUS_MASK;
                ADDR_MIE:           mie_d = wval & MIE_MASK;
                ADDR_MTVEC:         mtvec_d = {wval[31:2] & ADDR_MASK[31:2], 1'b0, wval[1:0] == 2'b01};
                ADDR_MCOUNTINHIBIT: mcountinhibit_d = wval & MCINH_MASK;
                ADDR_MSCRATCH:      mscratch_d = wval;
                ADDR_MEPC:          mepc_d = wval & ADDR_MASK & ~32'd1;
                ADDR_MCAUSE:        mcause_d = wval & MCAUSE_MASK;
                ADDR_MTVAL:         mtval_d = wval;
                ADDR_MIP: if (csr_op[1:0] == 2'b11) local_clear = src[16+:NUM_LOCAL_IRQ];
                ADDR_MCYCLE:        mcycle_d = {mcycle_q[63:32], wval} & CNT_MASK;
                ADDR_MCYCLEH:       mcycle_d = {wval, mcycle_q[31:0]} & CNT_MASK;
                ADDR_MINSTRET:      minstret_d = {minstret_q[63:32], wval} & CNT_MASK;
                ADDR_MINSTRETH:     minstret_d = {wval, minstret_q[31:0]} & CNT_MASK;
                default: ;
            endcase
        end

        // A new edge beats a same-cycle clear.
        lpend_d = (lpend_q & ~local_clear) | (local_irq & ~lirq_q);

        if (trap_trigger) begin
            mstatus_d        = mstatus_q;
            mstatus_d[7]     = mstatus_q[3];
            mstatus_d[3]     = 1'b0;
            mstatus_d[12:11] = 2'b11;
            mepc_d           = trap_pc & ADDR_MASK & ~32'd1;
            mcause_d         = trap_cause & MCAUSE_MASK;
            mtval_d          = trap_value;
        end else if (mret_trigger) begin
            mstatus_d[3]     = mstatus_d[7];
            mstatus_d[7]     = 1'b1;
            mstatus_d[12:11] = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_q       <= MSTATUS_RST;
            mie_q           <= '0;
            mtvec_q         <= '0;
            mcountinhibit_q <= '0;
            mscratch_q      <= '0;
            mepc_q          <= '0;
            mcause_q        <= '0;
            mtval_q         <= '0;
            mcycle_q        <= '0;
            minstret_q      <= '0;
            msip_q          <= 1'b0;
            mtip_q          <= 1'b0;
            meip_q          <= 1'b0;
            lpend_q         <= '0;
            lirq_q          <= '0;
        end else begin
            mstatus_q       <= mstatus_d;
            mie_q           <= mie_d;
            mtvec_q         <= mtvec_d;
            mcountinhibit_q <= mcountinhibit_d;
            mscratch_q      <= mscratch_d;
            mepc_q          <= mepc_d;
            mcause_q        <= mcause_d;
            mtval_q         <= mtval_d;
            mcycle_q        <= mcycle_d;
            minstret_q      <= minstret_d;
            msip_q          <= msip_d;
            mtip_q          <= mtip_d;
            meip_q          <= meip_d;
            lpend_q         <= lpend_d;
            lirq_q          <= lirq_d;
        end
    end

    // Fixed priority: MEI > MSI > MTI > lowest-numbered local line.
    always_comb begin
        irq_pend  = mip_val & mie_q;
        irq_req   = mstatus_q[3] && (irq_pend != '0);
        irq_cause = 32'h8000_000B;
        for (int i = int'(NUM_LOCAL_IRQ) - 1; i >= 0; i--) begin
            if (irq_pend[16+i]) irq_cause = 32'h8000_0000 | 32'(16 + i);
        end
        if (irq_pend[7])  irq_cause = 32'h8000_0007;
        if (irq_pend[3])  irq_cause = 32'h8000_0003;
        if (irq_pend[11]) irq_cause = 32'h8000_000B;
    end

    // Vectored mode only offsets asynchronous causes.
    always_comb begin
        vec_base = {mtvec_q[31:2], 2'b00} & ADDR_MASK;
        if (mtvec_q[0] && trap_cause[31]) begin
            trap_vector = (vec_base + {25'd0, trap_cause[4:0], 2'b00}) & ADDR_MASK;
        end else begin
            trap_vector = vec_base;
        end
    end

    assign mepc_out    = mepc_q;
    assign mstatus_out = mstatus_q;
    assign mie_out     = mie_q;
    assign mip_out     = mip_val;

endmodule

// File: tb/tb_rv32_csr_irq.sv
// Directed self-checking bench for rv32_csr_irq: counters, local/standard
// interrupts, priority, trap vectoring, trap/MRET collisions and decode.
module tb_rv32_csr_irq;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MCINH    = 12'h320;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTH   = 12'hB82;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_INSTRET  = 12'hC02;
    localparam logic [11:0] A_MHARTID  = 12'hF14;
    localparam logic [2:0]  OP_RW  = 3'b001;
    localparam logic [2:0]  OP_RS  = 3'b010;
    localparam logic [2:0]  OP_RC  = 3'b011;
    localparam logic [2:0]  OP_RSI = 3'b110;

    logic        clk, rst;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        csr_we, csr_illegal;
    logic [2:0]  csr_op;
    logic        instr_retire, trap_trigger, mret_trigger;
    logic [31:0] trap_cause, trap_pc, trap_value;
    logic        timer_interrupt, external_interrupt, software_interrupt;
    logic [3:0]  local_irq;
    logic        irq_req;
    logic [31:0] irq_cause, trap_vector, mepc_out, mstatus_out, mie_out, mip_out;

    int checks = 0;
    int errors = 0;

    rv32_csr_irq #(
        .NUM_LOCAL_IRQ(4),
        .COUNTER_WIDTH(64),
        .ADDR_MASK    (32'h00FF_FFFF),
        .HART_ID      (32'd0)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .csr_addr          (csr_addr),
        .csr_wdata         (csr_wdata),
        .csr_we            (csr_we),
        .csr_op            (csr_op),
        .csr_rdata         (csr_rdata),
        .csr_illegal       (csr_illegal),
        .instr_retire      (instr_retire),
        .trap_trigger      (trap_trigger),
        .trap_cause        (trap_cause),
        .trap_pc           (trap_pc),
        .trap_value        (trap_value),
        .mret_trigger      (mret_trigger),
        .timer_interrupt   (timer_interrupt),
        .external_interrupt(external_interrupt),
        .software_interrupt(software_interrupt),
        .local_irq         (local_irq),
        .irq_req           (irq_req),
        .irq_cause         (irq_cause),
        .trap_vector       (trap_vector),
        .mepc_out          (mepc_out),
        .mstatus_out       (mstatus_out),
        .mie_out           (mie_out),
        .mip_out           (mip_out)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [2:0] op, input logic [31:0] d);
        csr_addr  = a;
        csr_op    = op;
        csr_wdata = d;
        csr_we    = 1'b1;
        step();
        csr_we = 1'b0;
        csr_op = 3'b000;
    endtask

    task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
        csr_we   = 1'b0;
        csr_addr = a;
        #1;
        d = csr_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        checks++; if (mstatus_out !== 32'h1800) begin errors++; $display("FAIL reset_mstatus got %h exp %h", mstatus_out, 32'h1800); end
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL reset_irq_req got %b exp 0", irq_req); end
        checks++; if (irq_cause !== 32'h8000000B) begin errors++; $display("FAIL reset_irq_cause got %h exp 8000000b", irq_cause); end
        checks++; if (trap_vector !== 32'h0) begin errors++; $display("FAIL reset_trap_vector got %h exp 0", trap_vector); end
        checks++; if ({mie_out, mip_out, mepc_out} !== 96'h0) begin errors++; $display("FAIL reset_mie_mip_mepc got %h %h %h exp 0", mie_out, mip_out, mepc_out); end
        csr_rd(A_MCYCLE, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_mcycle got %h exp 0", rd); end
        csr_rd(A_MISA, rd);
        checks++; if (rd !== 32'h40000104) begin errors++; $display("FAIL misa got %h exp 40000104", rd); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_counters();
        logic [31:0] rd;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            instr_retire = (i % 2 == 0);
            if (i == 9) begin
                csr_addr = A_MCINH; csr_op = OP_RW; csr_wdata = 32'h1; csr_we = 1'b1;
            end
            step();
        end
        csr_we = 1'b0; instr_retire = 1'b0;
        csr_rd(A_MCYCLE, rd);
        checks++; if (rd !== 32'd10) begin errors++; $display("FAIL mcycle_10 got %0d exp 10", rd); end
        csr_rd(A_MINSTRET, rd);
        checks++; if (rd !== 32'd5) begin errors++; $display("FAIL minstret_5 got %0d exp 5", rd); end
        instr_retire = 1'b1;
        repeat (5) step();
        instr_retire = 1'b0;
        csr_rd(A_CYCLE, rd);
        checks++; if (rd !== 32'd10) begin errors++; $display("FAIL mcycle_inhibited got %0d exp 10", rd); end
        checks++; if (csr_illegal !== 1'b0) begin errors++; $display("FAIL cycle_read_legal got %b exp 0", csr_illegal); end
        csr_rd(A_INSTRET, rd);
        checks++; if (rd !== 32'd10) begin errors++; $display("FAIL instret_running got %0d exp 10", rd); end
        // wrap: load all-ones while inhibited, then release
        csr_wr(A_MCYCLE, OP_RW, 32'hFFFF_FFFF);
        csr_wr(A_MCYCLEH, OP_RW, 32'hFFFF_FFFF);
        csr_rd(A_MCYCLE, rd);
        checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_loaded got %h exp ffffffff", rd); end
        csr_wr(A_MCINH, OP_RW, 32'h0);
        step();
        csr_rd(A_MCYCLE, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wrap_lo got %h exp 0", rd); end
        csr_rd(A_MCYCLEH, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wrap_hi got %h exp 0", rd); end
        csr_wr(A_MCYCLEH, OP_RW, 32'h5);
        csr_rd(A_MCYCLE, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL hi_write_holds_lo got %h exp 0", rd); end
        csr_rd(A_MCYCLEH, rd);
        checks++; if (rd !== 32'h5) begin errors++; $display("FAIL hi_write got %h exp 5", rd); end
        instr_retire = 1'b1;
        csr_wr(A_MINSTRET, OP_RW, 32'h7);
        instr_retire = 1'b0;
        csr_rd(A_MINSTRET, rd);
        checks++; if (rd !== 32'h7) begin errors++; $display("FAIL minstret_write_wins got %h exp 7", rd); end
        csr_rd(A_MINSTH, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL minstreth_hold got %h exp 0", rd); end
    endtask

    task automatic test_local_irq();
        do_reset();
        csr_wr(A_MSTATUS, OP_RSI, 32'h8);
        csr_wr(A_MIE, OP_RW, 32'h0002_0000);
        local_irq = 4'b0010;
        #1;
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL local_before_edge got %b exp 0", irq_req); end
        step();
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL local_irq_req got %b exp 1", irq_req); end
        checks++; if (irq_cause !== 32'h80000011) begin errors++; $display("FAIL local_cause got %h exp 80000011", irq_cause); end
        local_irq = 4'b0000;
        repeat (2) step();
        checks++; if (mip_out !== 32'h0002_0000) begin errors++; $display("FAIL local_sticky got %h exp 00020000", mip_out); end
        csr_wr(A_MIP, OP_RW, 32'h0);
        csr_wr(A_MIP, OP_RS, 32'hFFFF_FFFF);
        checks++; if (mip_out !== 32'h0002_0000) begin errors++; $display("FAIL mip_rw_rs_ignored got %h exp 00020000", mip_out); end
        csr_wr(A_MIP, OP_RC, 32'h0002_0000);
        checks++; if (irq_req !== 1'b0 || mip_out !== 32'h0) begin errors++; $display("FAIL local_clear got req %b mip %h exp 0 0", irq_req, mip_out); end
        local_irq = 4'b0010;
        csr_wr(A_MIP, OP_RC, 32'h0002_0000);
        checks++; if (mip_out !== 32'h0002_0000) begin errors++; $display("FAIL set_beats_clear got %h exp 00020000", mip_out); end
        csr_wr(A_MIP, OP_RC, 32'h0002_0000);
        checks++; if (mip_out !== 32'h0) begin errors++; $display("FAIL level_no_reset got %h exp 0", mip_out); end
        local_irq = 4'b0000;
    endtask

    task automatic test_priority();
        do_reset();
        csr_wr(A_MSTATUS, OP_RSI, 32'h8);
        csr_wr(A_MIE, OP_RW, 32'h0001_0888);
        timer_interrupt = 1'b1; software_interrupt = 1'b1; local_irq = 4'b0001;
        step();
        local_irq = 4'b0000;
        checks++; if (irq_cause !== 32'h80000003 || irq_req !== 1'b1) begin errors++; $display("FAIL prio_msi got %h req %b exp 80000003 1", irq_cause, irq_req); end
        external_interrupt = 1'b1;
        step();
        checks++; if (irq_cause !== 32'h8000000B) begin errors++; $display("FAIL prio_mei got %h exp 8000000b", irq_cause); end
        checks++; if (mip_out !== 32'h0001_0888) begin errors++; $display("FAIL prio_mip got %h exp 00010888", mip_out); end
        external_interrupt = 1'b0; software_interrupt = 1'b0;
        step();
        checks++; if (irq_cause !== 32'h80000007) begin errors++; $display("FAIL prio_mti got %h exp 80000007", irq_cause); end
        timer_interrupt = 1'b0;
        step();
        checks++; if (irq_cause !== 32'h80000010) begin errors++; $display("FAIL prio_local0 got %h exp 80000010", irq_cause); end
        csr_wr(A_MIE, OP_RW, 32'h0000_0888);
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL mie_masks got %b exp 0", irq_req); end
        csr_wr(A_MIE, OP_RW, 32'h0001_0000);
        csr_wr(A_MSTATUS, OP_RW, 32'h1800);
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL global_mie_off got %b exp 0", irq_req); end
    endtask

    task automatic test_vector();
        logic [31:0] rd;
        do_reset();
        csr_wr(A_MTVEC, OP_RW, 32'h0000_1001);
        trap_cause = 32'h8000_0007;
        #1;
        checks++; if (trap_vector !== 32'h101C) begin errors++; $display("FAIL vectored got %h exp 0000101c", trap_vector); end
        trap_cause = 32'h0000_0002;
        #1;
        checks++; if (trap_vector !== 32'h1000) begin errors++; $display("FAIL vectored_exc got %h exp 00001000", trap_vector); end
        csr_wr(A_MTVEC, OP_RW, 32'hFF00_2003);
        trap_cause = 32'h8000_0003;
        csr_rd(A_MTVEC, rd);
        checks++; if (rd !== 32'h0000_2000) begin errors++; $display("FAIL mtvec_mode3_mask got %h exp 00002000", rd); end
        checks++; if (trap_vector !== 32'h2000) begin errors++; $display("FAIL mode3_direct got %h exp 00002000", trap_vector); end
        trap_cause = 32'h0;
    endtask

    task automatic test_collision();
        logic [31:0] rd;
        do_reset();
        csr_wr(A_MSTATUS, OP_RW, 32'h1808);
        trap_trigger = 1'b1; trap_pc = 32'h200; trap_cause = 32'h2; trap_value = 32'hDEAD_BEEF;
        csr_wr(A_MEPC, OP_RW, 32'h300);
        trap_trigger = 1'b0;
        checks++; if (mepc_out !== 32'h200) begin errors++; $display("FAIL trap_mepc got %h exp 00000200", mepc_out); end
        checks++; if (mstatus_out !== 32'h1880) begin errors++; $display("FAIL trap_mstatus got %h exp 00001880", mstatus_out); end
        csr_rd(A_MTVAL, rd);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL trap_mtval got %h exp deadbeef", rd); end
        mret_trigger = 1'b1;
        step();
        mret_trigger = 1'b0;
        checks++; if (mstatus_out !== 32'h0088) begin errors++; $display("FAIL mret_mstatus got %h exp 00000088", mstatus_out); end
        trap_trigger = 1'b1; mret_trigger = 1'b1; trap_pc = 32'hFF00_0405; trap_cause = 32'hFFFF_FFEB;
        csr_wr(A_MSCRATCH, OP_RW, 32'h55);
        trap_trigger = 1'b0; mret_trigger = 1'b0; trap_cause = 32'h0;
        checks++; if (mstatus_out !== 32'h1880) begin errors++; $display("FAIL trap_beats_mret got %h exp 00001880", mstatus_out); end
        checks++; if (mepc_out !== 32'h404) begin errors++; $display("FAIL mepc_mask got %h exp 00000404", mepc_out); end
        csr_rd(A_MCAUSE, rd);
        checks++; if (rd !== 32'h8000_000B) begin errors++; $display("FAIL mcause_mask got %h exp 8000000b", rd); end
        csr_rd(A_MSCRATCH, rd);
        checks++; if (rd !== 32'h55) begin errors++; $display("FAIL write_beside_trap got %h exp 00000055", rd); end
        rst = 1'b1;
        #1;
        checks++; if (mstatus_out !== 32'h1800 || mepc_out !== 32'h0) begin errors++; $display("FAIL async_reset got %h %h exp 00001800 0", mstatus_out, mepc_out); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_decode();
        logic [31:0] rd;
        csr_addr = 12'h7C0; csr_we = 1'b0;
        #1;
        checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL unimpl_illegal got %b exp 1", csr_illegal); end
        csr_addr = A_CYCLE; csr_op = OP_RW; csr_we = 1'b1;
        #1;
        checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL ro_write_illegal got %b exp 1", csr_illegal); end
        csr_we = 1'b0;
        csr_rd(A_MHARTID, rd);
        checks++; if (rd !== 32'h0 || csr_illegal !== 1'b0) begin errors++; $display("FAIL mhartid got %h ill %b exp 0 0", rd, csr_illegal); end
        csr_wr(A_MIE, OP_RW, 32'hFFFF_FFFF);
        checks++; if (mie_out !== 32'h000F_0888) begin errors++; $display("FAIL mie_mask got %h exp 000f0888", mie_out); end
        csr_wr(A_MCAUSE, OP_RW, 32'hFFFF_FFFF);
        csr_rd(A_MCAUSE, rd);
        checks++; if (rd !== 32'h8000_001F) begin errors++; $display("FAIL mcause_wmask got %h exp 8000001f", rd); end
        csr_wr(A_MSTATUS, OP_RW, 32'hFFFF_FFFF);
        checks++; if (mstatus_out !== 32'h1FFF) begin errors++; $display("FAIL mstatus_mask got %h exp 00001fff", mstatus_out); end
        csr_wr(A_MISA, OP_RW, 32'h0);
        csr_rd(A_MISA, rd);
        checks++; if (rd !== 32'h40000104) begin errors++; $display("FAIL misa_ignores got %h exp 40000104", rd); end
    endtask

    initial begin
        rst = 1'b1;
        csr_addr = '0; csr_wdata = '0; csr_we = 1'b0; csr_op = '0;
        instr_retire = 1'b0; trap_trigger = 1'b0; mret_trigger = 1'b0;
        trap_cause = '0; trap_pc = '0; trap_value = '0;
        timer_interrupt = 1'b0; external_interrupt = 1'b0; software_interrupt = 1'b0;
        local_irq = '0;
        step();
        test_reset();
        test_counters();
        test_local_irq();
        test_priority();
        test_vector();
        test_collision();
        test_decode();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
